// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_pkg
// Purpose  : Shared pointer/count types, flag helpers and read-mode encoding
//            for the programmable FIFO.
// Revision : 1.0 - initial release
// ============================================================================
package fifo_pkg;

  // Pointers and counts are passed to the helpers zero-extended to 32 bits
  // so one function serves every DEPTH.
  typedef logic [31:0] ptr_t;
  typedef logic [31:0] cnt_t;

  // Read-mode selection derived from the FWFT parameter.
  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  // Empty when both pointers (wrap bit and address) match.
  function automatic logic is_empty(input ptr_t wr, input ptr_t rd);
    return (wr == rd);
  endfunction

  // Full when the addresses match but the wrap bits differ.
  // aw is the address width; the wrap bit sits at position aw.
  function automatic logic is_full(input ptr_t wr, input ptr_t rd, input int unsigned aw);
    ptr_t mask;
    mask = (ptr_t'(2) << aw) - ptr_t'(1);
    return (((wr ^ rd) & mask) == (ptr_t'(1) << aw));
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_ram_2p.sv
`default_nettype none
// ============================================================================
// Module   : fifo_ram_2p
// Purpose  : DEPTH x DATA_WIDTH register array with one synchronous write
//            port and one asynchronous read port. Contents are not reset.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_ram_2p #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [$clog2(DEPTH)-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0]     raddr,
  output logic [DATA_WIDTH-1:0]        rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port: store one word per accepted write.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule
`default_nettype wire

// File: rtl/fifo_mem_prog.sv
`default_nettype none
// ============================================================================
// Module   : fifo_mem_prog
// Purpose  : Single-clock FIFO with power-of-2 depth, programmable
//            almost-full/almost-empty thresholds, occupancy count, sticky
//            overflow/underflow flags and standard or FWFT read mode.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_mem_prog
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16,
  parameter int FWFT       = 0
) (
  input  logic                       clk_in,
  input  logic                       areset,
  input  logic                       trans_write,
  input  logic [DATA_WIDTH-1:0]      data_in,
  input  logic                       trans_read,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic                       data_valid,
  input  logic [$clog2(DEPTH):0]     afull_thresh,
  input  logic [$clog2(DEPTH):0]     aempty_thresh,
  input  logic                       err_clr,
  output logic [$clog2(DEPTH):0]     fill_count,
  output logic                       full_ind,
  output logic                       empty_ind,
  output logic                       afull_ind,
  output logic                       aempty_ind,
  output logic                       overflow_ind,
  output logic                       underflow_ind
);

  localparam int         ADDR_W = $clog2(DEPTH);
  localparam int         CNT_W  = ADDR_W + 1;
  localparam fifo_mode_e MODE   = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

  logic [CNT_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      rd_ptr;
  logic                  rd_acc;
  logic                  wr_acc;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // Flags come only from registered pointers; trans_* never reach them
  // combinationally.
  assign fill_count = wr_ptr - rd_ptr;
  assign empty_ind  = is_empty(ptr_t'(wr_ptr), ptr_t'(rd_ptr));
  assign full_ind   = is_full(ptr_t'(wr_ptr), ptr_t'(rd_ptr), ADDR_W);
  assign afull_ind  = (fill_count >= afull_thresh);
  assign aempty_ind = (fill_count <= aempty_thresh);

  // A write into a full FIFO is still accepted when a read frees a slot in
  // the same cycle.
  assign rd_acc = trans_read & ~empty_ind;
  assign wr_acc = trans_write & (~full_ind | rd_acc);

  fifo_ram_2p #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk   (clk_in),
    .we    (wr_acc),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (data_in),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (ram_rdata)
  );

  // Pointer advance on accepted transfers; reset empties the FIFO at once.
  always_ff @(posedge clk_in or posedge areset) begin
    if (areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + CNT_W'(1);
      if (rd_acc) rd_ptr <= rd_ptr + CNT_W'(1);
    end
  end

  // Sticky error flags; a new error in the same cycle as err_clr wins.
  always_ff @(posedge clk_in or posedge areset) begin
    if (areset) begin
      overflow_ind  <= 1'b0;
      underflow_ind <= 1'b0;
    end else begin
      if (trans_write & ~wr_acc) overflow_ind <= 1'b1;
      else if (err_clr)          overflow_ind <= 1'b0;
      if (trans_read & ~rd_acc)  underflow_ind <= 1'b1;
      else if (err_clr)          underflow_ind <= 1'b0;
    end
  end

  generate
    if (MODE == FIFO_FWFT) begin : g_fwft
      // Head word is presented directly from the array.
      assign data_out   = ram_rdata;
      assign data_valid = ~empty_ind;
    end else begin : g_std
      logic [DATA_WIDTH-1:0] out_q;
      logic                  valid_q;

      // Registered read: capture the head on a pop, valid pulses one cycle.
      always_ff @(posedge clk_in or posedge areset) begin
        if (areset) begin
          out_q   <= '0;
          valid_q <= 1'b0;
        end else begin
          valid_q <= rd_acc;
          if (rd_acc) out_q <= ram_rdata;
        end
      end

      assign data_out   = out_q;
      assign data_valid = valid_q;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_fifo_mem_prog.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_mem_prog
// Purpose  : Directed self-checking bench for fifo_mem_prog (DEPTH=8,
//            DATA_WIDTH=16), one standard-mode and one FWFT instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_mem_prog;

  localparam int DW = 16;
  localparam int DP = 8;
  localparam int CW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Standard-mode instance signals
  logic          areset = 1'b1;
  logic          trans_write = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          trans_read = 1'b0;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic [CW-1:0] afull_thresh = '0;
  logic [CW-1:0] aempty_thresh = '0;
  logic          err_clr = 1'b0;
  logic [CW-1:0] fill_count;
  logic          full_ind, empty_ind, afull_ind, aempty_ind;
  logic          overflow_ind, underflow_ind;

  // FWFT instance signals
  logic          f_areset = 1'b1;
  logic          f_write = 1'b0;
  logic [DW-1:0] f_din = '0;
  logic          f_read = 1'b0;
  logic [DW-1:0] f_dout;
  logic          f_valid;
  logic [CW-1:0] f_count;
  logic          f_full, f_empty, f_afull, f_aempty, f_ovf, f_udf;

  int n_cmp = 0;
  int n_err = 0;

  fifo_mem_prog #(.DATA_WIDTH(DW), .DEPTH(DP), .FWFT(0)) u_std (
    .clk_in(clk), .areset(areset), .trans_write(trans_write), .data_in(data_in),
    .trans_read(trans_read), .data_out(data_out), .data_valid(data_valid),
    .afull_thresh(afull_thresh), .aempty_thresh(aempty_thresh), .err_clr(err_clr),
    .fill_count(fill_count), .full_ind(full_ind), .empty_ind(empty_ind),
    .afull_ind(afull_ind), .aempty_ind(aempty_ind),
    .overflow_ind(overflow_ind), .underflow_ind(underflow_ind)
  );

  fifo_mem_prog #(.DATA_WIDTH(DW), .DEPTH(DP), .FWFT(1)) u_fwft (
    .clk_in(clk), .areset(f_areset), .trans_write(f_write), .data_in(f_din),
    .trans_read(f_read), .data_out(f_dout), .data_valid(f_valid),
    .afull_thresh(4'd8), .aempty_thresh(4'd0), .err_clr(1'b0),
    .fill_count(f_count), .full_ind(f_full), .empty_ind(f_empty),
    .afull_ind(f_afull), .aempty_ind(f_aempty),
    .overflow_ind(f_ovf), .underflow_ind(f_udf)
  );

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    areset = 1'b1; afull_thresh = 4'd0; aempty_thresh = 4'd0;
    cyc(); cyc();
    n_cmp++; if (fill_count !== 4'd0) begin n_err++; $display("FAIL rst_count got %0d want 0", fill_count); end
    n_cmp++; if (empty_ind !== 1'b1 || full_ind !== 1'b0) begin n_err++; $display("FAIL rst_flags empty=%b full=%b want 1/0", empty_ind, full_ind); end
    n_cmp++; if (aempty_ind !== 1'b1 || afull_ind !== 1'b1) begin n_err++; $display("FAIL rst_thr aempty=%b afull=%b want 1/1", aempty_ind, afull_ind); end
    n_cmp++; if (data_valid !== 1'b0 || data_out !== 16'h0) begin n_err++; $display("FAIL rst_out valid=%b data=%h want 0/0000", data_valid, data_out); end
    n_cmp++; if (overflow_ind !== 1'b0 || underflow_ind !== 1'b0) begin n_err++; $display("FAIL rst_err ovf=%b udf=%b want 0/0", overflow_ind, underflow_ind); end
    afull_thresh = 4'd8; aempty_thresh = 4'd0;
    #1;
    n_cmp++; if (afull_ind !== 1'b0) begin n_err++; $display("FAIL rst_afull8 got %b want 0", afull_ind); end
    areset = 1'b0;
    cyc();
  endtask

  task automatic test_fill_overflow();
    for (int i = 1; i <= 8; i++) begin
      trans_write = 1'b1; data_in = 16'(i);
      cyc();
    end
    trans_write = 1'b0;
    n_cmp++; if (full_ind !== 1'b1 || fill_count !== 4'd8) begin n_err++; $display("FAIL fill_full full=%b count=%0d want 1/8", full_ind, fill_count); end
    n_cmp++; if (afull_ind !== 1'b1 || aempty_ind !== 1'b0) begin n_err++; $display("FAIL fill_thr afull=%b aempty=%b want 1/0", afull_ind, aempty_ind); end
    trans_write = 1'b1; data_in = 16'h0009;
    cyc();
    trans_write = 1'b0;
    n_cmp++; if (overflow_ind !== 1'b1 || fill_count !== 4'd8) begin n_err++; $display("FAIL ovf ovf=%b count=%0d want 1/8", overflow_ind, fill_count); end
  endtask

  task automatic test_read_underflow();
    for (int i = 1; i <= 8; i++) begin
      trans_read = 1'b1;
      cyc();
      n_cmp++; if (data_out !== 16'(i) || data_valid !== 1'b1) begin n_err++; $display("FAIL rd_%0d data=%h valid=%b want %h/1", i, data_out, data_valid, 16'(i)); end
    end
    trans_read = 1'b0;
    cyc();
    n_cmp++; if (data_valid !== 1'b0 || empty_ind !== 1'b1) begin n_err++; $display("FAIL rd_done valid=%b empty=%b want 0/1", data_valid, empty_ind); end
    trans_read = 1'b1;
    cyc();
    trans_read = 1'b0;
    n_cmp++; if (underflow_ind !== 1'b1 || data_out !== 16'h0008 || data_valid !== 1'b0) begin n_err++; $display("FAIL udf udf=%b data=%h valid=%b want 1/0008/0", underflow_ind, data_out, data_valid); end
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    n_cmp++; if (underflow_ind !== 1'b0 || overflow_ind !== 1'b0) begin n_err++; $display("FAIL clr1 udf=%b ovf=%b want 0/0", underflow_ind, overflow_ind); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 6; i++) begin trans_write = 1'b1; data_in = 16'h0100 + 16'(i); cyc(); end
    trans_write = 1'b0;
    for (int i = 0; i < 6; i++) begin
      trans_read = 1'b1; cyc();
      n_cmp++; if (data_out !== 16'h0100 + 16'(i)) begin n_err++; $display("FAIL wrap_pre%0d got %h want %h", i, data_out, 16'h0100 + 16'(i)); end
    end
    trans_read = 1'b0;
    for (int i = 0; i < 8; i++) begin trans_write = 1'b1; data_in = 16'h0200 + 16'(i); cyc(); end
    trans_write = 1'b0;
    n_cmp++; if (full_ind !== 1'b1 || fill_count !== 4'd8) begin n_err++; $display("FAIL wrap_full full=%b count=%0d want 1/8", full_ind, fill_count); end
    for (int i = 0; i < 8; i++) begin
      trans_read = 1'b1; cyc();
      n_cmp++; if (data_out !== 16'h0200 + 16'(i)) begin n_err++; $display("FAIL wrap_rd%0d got %h want %h", i, data_out, 16'h0200 + 16'(i)); end
    end
    trans_read = 1'b0;
    cyc();
    n_cmp++; if (empty_ind !== 1'b1) begin n_err++; $display("FAIL wrap_empty got %b want 1", empty_ind); end
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 8; i++) begin trans_write = 1'b1; data_in = 16'h0300 + 16'(i); cyc(); end
    trans_write = 1'b1; trans_read = 1'b1; data_in = 16'h03FF;
    cyc();
    trans_write = 1'b0; trans_read = 1'b0;
    n_cmp++; if (fill_count !== 4'd8 || overflow_ind !== 1'b0) begin n_err++; $display("FAIL b2b_full count=%0d ovf=%b want 8/0", fill_count, overflow_ind); end
    n_cmp++; if (data_out !== 16'h0301 || data_valid !== 1'b1) begin n_err++; $display("FAIL b2b_head data=%h valid=%b want 0301/1", data_out, data_valid); end
    for (int i = 2; i <= 9; i++) begin
      trans_read = 1'b1; cyc();
      n_cmp++; if (data_out !== ((i == 9) ? 16'h03FF : 16'h0300 + 16'(i))) begin n_err++; $display("FAIL b2b_rd%0d got %h", i, data_out); end
    end
    trans_read = 1'b0;
    trans_write = 1'b1; trans_read = 1'b1; data_in = 16'h0400;
    cyc();
    trans_write = 1'b0; trans_read = 1'b0;
    n_cmp++; if (fill_count !== 4'd1 || underflow_ind !== 1'b1 || data_valid !== 1'b0) begin n_err++; $display("FAIL b2b_empty count=%0d udf=%b valid=%b want 1/1/0", fill_count, underflow_ind, data_valid); end
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    n_cmp++; if (underflow_ind !== 1'b0 || overflow_ind !== 1'b0) begin n_err++; $display("FAIL b2b_clr udf=%b ovf=%b want 0/0", underflow_ind, overflow_ind); end
    trans_read = 1'b1; cyc(); trans_read = 1'b0;
    n_cmp++; if (data_out !== 16'h0400 || empty_ind !== 1'b1) begin n_err++; $display("FAIL b2b_last data=%h empty=%b want 0400/1", data_out, empty_ind); end
  endtask

  task automatic test_thresholds();
    afull_thresh = 4'd6; aempty_thresh = 4'd2;
    #1;
    n_cmp++; if (aempty_ind !== 1'b1 || afull_ind !== 1'b0) begin n_err++; $display("FAIL thr0 aempty=%b afull=%b want 1/0", aempty_ind, afull_ind); end
    for (int k = 1; k <= 6; k++) begin
      trans_write = 1'b1; data_in = 16'h0500 + 16'(k); cyc(); trans_write = 1'b0;
      n_cmp++; if (aempty_ind !== (k <= 2) || afull_ind !== (k >= 6)) begin n_err++; $display("FAIL thr_c%0d aempty=%b afull=%b want %b/%b", k, aempty_ind, afull_ind, (k <= 2), (k >= 6)); end
    end
    afull_thresh = 4'd0; aempty_thresh = 4'd8;
    #1;
    n_cmp++; if (aempty_ind !== 1'b1 || afull_ind !== 1'b1) begin n_err++; $display("FAIL thr_edge aempty=%b afull=%b want 1/1", aempty_ind, afull_ind); end
    afull_thresh = 4'd7; aempty_thresh = 4'd5;
    #1;
    n_cmp++; if (aempty_ind !== 1'b0 || afull_ind !== 1'b0) begin n_err++; $display("FAIL thr_mid aempty=%b afull=%b want 0/0", aempty_ind, afull_ind); end
  endtask

  task automatic test_fwft();
    f_areset = 1'b0;
    cyc();
    n_cmp++; if (f_valid !== 1'b0 || f_empty !== 1'b1) begin n_err++; $display("FAIL fw_init valid=%b empty=%b want 0/1", f_valid, f_empty); end
    f_write = 1'b1; f_din = 16'hA5A5; cyc(); f_write = 1'b0;
    n_cmp++; if (f_dout !== 16'hA5A5 || f_valid !== 1'b1) begin n_err++; $display("FAIL fw_first data=%h valid=%b want a5a5/1", f_dout, f_valid); end
    for (int i = 1; i <= 4; i++) begin f_write = 1'b1; f_din = 16'h1100 * 16'(i); cyc(); end
    f_write = 1'b0;
    n_cmp++; if (f_count !== 4'd5 || f_dout !== 16'hA5A5) begin n_err++; $display("FAIL fw_five count=%0d data=%h want 5/a5a5", f_count, f_dout); end
    #2 f_areset = 1'b1;
    #1;
    n_cmp++; if (f_count !== 4'd0 || f_empty !== 1'b1 || f_valid !== 1'b0) begin n_err++; $display("FAIL fw_arst count=%0d empty=%b valid=%b want 0/1/0", f_count, f_empty, f_valid); end
    #1 f_areset = 1'b0;
    f_write = 1'b1; f_din = 16'hBEEF; cyc();
    f_din = 16'hCAFE; cyc(); f_write = 1'b0;
    n_cmp++; if (f_dout !== 16'hBEEF || f_count !== 4'd2) begin n_err++; $display("FAIL fw_post data=%h count=%0d want beef/2", f_dout, f_count); end
    f_read = 1'b1; cyc();
    n_cmp++; if (f_dout !== 16'hCAFE || f_valid !== 1'b1) begin n_err++; $display("FAIL fw_pop data=%h valid=%b want cafe/1", f_dout, f_valid); end
    cyc(); f_read = 1'b0;
    n_cmp++; if (f_empty !== 1'b1 || f_valid !== 1'b0 || f_udf !== 1'b0) begin n_err++; $display("FAIL fw_drain empty=%b valid=%b udf=%b want 1/0/0", f_empty, f_valid, f_udf); end
  endtask

  initial begin
    test_reset();
    test_fill_overflow();
    test_read_underflow();
    test_wrap();
    test_back_to_back();
    test_thresholds();
    test_fwft();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
